// File: rtl/mic_sample_fifo.sv
// ============================================================================
// Module  : mic_sample_fifo
// Brief   : APB-attached circular sample buffer with fill status, sticky
//           overflow flag and a threshold interrupt.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mic_sample_fifo #(
    parameter int DEPTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    input  logic        PSEL,
    input  logic [11:0] PADDR,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        irq
);

    localparam int              CW            = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]   c_FULL        = CW'(DEPTH);
    localparam logic [CW-1:0]   c_CNT_ONE     = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [6:0]      c_THRESH_RST  = 7'(DEPTH / 2);
    localparam logic [3:0]      c_ADDR_DATA   = 4'h0;
    localparam logic [3:0]      c_ADDR_STATUS = 4'h4;
    localparam logic [3:0]      c_ADDR_CTRL   = 4'h8;
    localparam logic [3:0]      c_ADDR_CLEAR  = 4'hC;

    logic [15:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  en_q, en_d;
    logic                  irq_en_q, irq_en_d;
    logic [6:0]            thresh_q, thresh_d;
    logic                  irq_q, irq_d;

    logic       w_rd, w_wr, w_empty, w_full;
    logic       w_pop, w_push, w_drop, w_flush, w_ctrl_wr, w_mem_we;
    logic [3:0] w_addr;
    logic [31:0] w_status;
    logic       w_unused_bits;

    assign w_addr    = PADDR[3:0];
    assign w_rd      = PSEL & PENABLE & ~PWRITE;
    assign w_wr      = PSEL & PENABLE & PWRITE;
    assign w_empty   = (count_q == '0);
    assign w_full    = (count_q == c_FULL);
    assign w_pop     = w_rd & (w_addr == c_ADDR_DATA) & ~w_empty;
    assign w_flush   = w_wr & (w_addr == c_ADDR_CLEAR) & PWDATA[0];
    assign w_ctrl_wr = w_wr & (w_addr == c_ADDR_CTRL);
    // A pop frees the head slot this same edge, so a full buffer still accepts.
    assign w_push    = sample_valid & en_q & (~w_full | w_pop);
    assign w_drop    = sample_valid & en_q & w_full & ~w_pop;
    assign w_mem_we  = w_push & ~w_flush;

    assign w_unused_bits = ^{PADDR[11:4], PWDATA[31:15], PWDATA[7:2]};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (w_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + c_PTR_ONE;
            if (w_pop)  rd_ptr_d = rd_ptr_q + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_CNT_ONE;
                2'b01:   count_d = count_q - c_CNT_ONE;
                default: count_d = count_q;
            endcase
            if (w_drop) ovf_d = 1'b1;
        end
    end

    always_comb begin
        en_d     = en_q;
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;
        if (w_ctrl_wr) begin
            en_d     = PWDATA[0];
            irq_en_d = PWDATA[1];
            thresh_d = PWDATA[14:8];
        end
        // Evaluated on next-state values so irq lines up with the new count.
        irq_d = irq_en_d & ((count_d >= thresh_d[CW-1:0]) | ovf_d);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            en_q     <= 1'b1;
            irq_en_q <= 1'b0;
            thresh_q <= c_THRESH_RST;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            thresh_q <= thresh_d;
            irq_q    <= irq_d;
        end
    end

    always_ff @(posedge PCLK) begin
        if (w_mem_we) mem_q[wr_ptr_q] <= sample_data;
    end

    always_comb begin
        w_status                = '0;
        w_status[CW+7:8]        = count_q;
        w_status[2]             = ovf_q;
        w_status[1]             = w_full;
        w_status[0]             = w_empty;
    end

    always_comb begin
        PRDATA = '0;
        case (w_addr)
            c_ADDR_DATA:   PRDATA = w_empty ? 32'h0 : {15'h0, 1'b1, mem_q[rd_ptr_q]};
            c_ADDR_STATUS: PRDATA = w_status;
            c_ADDR_CTRL:   PRDATA = {17'h0, thresh_q, 6'h0, irq_en_q, en_q};
            c_ADDR_CLEAR:  PRDATA = 32'h0;
            default:       PRDATA = 32'hDEAD_DEAD;
        endcase
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;
    assign irq     = irq_q;

endmodule

`default_nettype wire

// File: doc/mic_sample_fifo.md
Name: mic_sample_fifo

Overview:
- APB-attached circular buffer between the SPI microphone capture stage and the CPU.
- Accepts one 16-bit sample per `sample_valid` strobe from the SPI capture stage and stores up to DEPTH samples.
- The CPU drains the buffer through APB reads, which pop one sample each.
- Provides fill-level status, a sticky overflow flag, and a threshold interrupt, so firmware can burst-read blocks instead of polling every sample.

Parameters:
- DEPTH, 16, number of sample entries; must be a power of two, range 4..64.
- DEPTH_LOG2, 4, log2(DEPTH); sets pointer width. Count width is DEPTH_LOG2+1.

Ports:
- PCLK  input  1  system/APB clock; the only clock.
- PRESETn  input  1  asynchronous active-low reset.
- sample_valid  input  1  one-PCLK strobe marking a new sample from the SPI capture stage.
- sample_data  input  16  sample value, qualified by sample_valid.
- PSEL  input  1  APB select.
- PADDR  input  12  APB address; only PADDR[3:0] is decoded.
- PENABLE  input  1  APB access phase.
- PWRITE  input  1  APB write control.
- PWDATA  input  32  APB write data.
- PRDATA  output  32  APB read data (combinational).
- PREADY  output  1  tied 1.
- PSLVERR  output  1  tied 0.
- irq  output  1  registered level interrupt.

Behaviour:
- Reset (async, PRESETn low):
  - Pointers = 0, count = 0, overflow = 0, irq = 0.
  - CTRL.enable = 1, CTRL.irq_en = 0, CTRL.thresh = DEPTH/2.
  - Storage contents are don't-care.
  - Reset mid-operation discards all stored samples immediately.
- Decode: rd = PSEL & PENABLE & ~PWRITE; wr = PSEL & PENABLE & PWRITE. Every access completes in one cycle.
- Register map (PADDR[3:0]):
  - 0x0 DATA (RO): bit16 = valid, [15:0] = head sample. When empty: 0x0000_0000.
  - 0x4 STATUS (RO): [DEPTH_LOG2+8:8] = count, bit2 = overflow, bit1 = full, bit0 = empty.
  - 0x8 CTRL (RW): bit0 = enable, bit1 = irq_en, [14:8] = thresh (7 bits; upper bits beyond count width ignored on compare). Reads return written value; other bits read as 0.
  - 0xC CLEAR (WO): writing any value with PWDATA[0] = 1 flushes. Reads return 0.
  - Any other offset: read 32'hDEADDEAD, write ignored.
- Flush: pointers = 0, count = 0, overflow = 0. Takes effect at the end of the CLEAR write cycle.
- Pop: rd to 0x0 while count != 0. PRDATA shows the head during the access cycle; the read pointer advances at that PCLK edge. Read of 0x0 while empty returns 0 and does not move pointers.
- Push: sample_valid & enable & (~full | pop_this_cycle). Writes sample_data at the write pointer; write pointer increments.
- Overflow: sample_valid & enable & full & ~pop_this_cycle drops the sample and sets overflow (sticky until flush or reset). Stored data is never overwritten.
- enable = 0: sample_valid is ignored entirely (no push, no overflow). Pops remain allowed.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged; both pointers advance.
  - Push while empty with a DATA read in the same cycle: the read returns valid = 0 and no pop; the push lands.
  - Flush with push or pop in the same cycle: flush wins; the incoming sample is dropped and overflow is not set.
- Pointers wrap modulo DEPTH. count saturates logically at DEPTH via the full rule, never exceeding it.
- full = (count == DEPTH); empty = (count == 0). Both are derived from the registered count.
- irq: registered next-cycle, irq <= irq_en & ((count_next >= thresh) | overflow_next). thresh = 0 with irq_en = 1 gives a constant irq.
- Latency:
  - Sample visible in DATA/STATUS the cycle after its sample_valid.
  - irq asserts the cycle after the sample that crosses thresh, i.e. in the same cycle count reflects it.

Test Plan:
- Reset, read 0x4 → 0x0000_0001. Read 0x0 → 0x0000_0000. Read 0x8 → 0x0000_0801. Read 0x10 → 0xDEADDEAD.
- Push 3 samples 0x1111, 0x2222, 0x3333, then read 0x0 three times → 0x0001_1111, 0x0001_2222, 0x0001_3333. Fourth read → 0x0000_0000. STATUS empty = 1.
- Push 17 samples 0x0000..0x0010 with DEPTH = 16:
  - STATUS → count 16, full = 1, overflow = 1.
  - 16 pops return 0x0000..0x000F; 0x0010 is lost.
  - Write 0xC = 1 → STATUS 0x0000_0001.
- Fill to 16, then in one cycle assert sample_valid = 0xABCD together with a DATA read → read returns the head, count stays 16, overflow stays 0, 0xABCD is the last popped value.
- Write CTRL = 0x0000_0403 (thresh 4, irq_en, enable). Push 3 samples → irq = 0. Push the 4th → irq = 1 on the next edge. One pop → irq = 0 the cycle after.
- Push 5 samples, assert PRESETn low mid-stream for 1 cycle → STATUS = 0x0000_0001, irq = 0, CTRL back to 0x0000_0801. A subsequent push of 0x5A5A reads back 0x0001_5A5A.
